// File: rtl/cmp_dx_sched_pkg.sv
// Shared types and constants for the duplex comparator scheduler.
package cmp_dx_sched_pkg;

  localparam logic MODE_FULL = 1'b0;
  localparam logic MODE_LANE = 1'b1;

  localparam int unsigned REQ0 = 0;
  localparam int unsigned REQ1 = 1;

  typedef enum logic {
    PTR_R0 = 1'b0,
    PTR_R1 = 1'b1
  } ptr_e;

  typedef struct packed {
    logic eq;
    logic lt;
    logic gt;
  } flags_t;

endpackage

// File: rtl/cmp_dx_core.sv
// Combinational duplex comparator: one full-width compare, or two independent lane compares.
module cmp_dx_core #(
  parameter int unsigned width    = 8,
  parameter int unsigned p1_width = 4
) (
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  input  logic             tc,
  input  logic             dplx,
  output logic             eq1,
  output logic             lt1,
  output logic             gt1,
  output logic             eq2,
  output logic             lt2,
  output logic             gt2
);

  localparam int unsigned W2 = width - p1_width;

  logic [width-1:0]    fa, fb;
  logic [p1_width-1:0] la1, lb1;
  logic [W2-1:0]       la2, lb2;

  // Flipping the sign bit turns a signed compare into an unsigned one.
  always_comb begin
    fa  = a;
    fb  = b;
    fa[width-1] = a[width-1] ^ tc;
    fb[width-1] = b[width-1] ^ tc;
    la1 = a[p1_width-1:0];
    lb1 = b[p1_width-1:0];
    la1[p1_width-1] = a[p1_width-1] ^ tc;
    lb1[p1_width-1] = b[p1_width-1] ^ tc;
    la2 = a[width-1:p1_width];
    lb2 = b[width-1:p1_width];
    la2[W2-1] = a[width-1] ^ tc;
    lb2[W2-1] = b[width-1] ^ tc;

    eq1 = 1'b0; lt1 = 1'b0; gt1 = 1'b0;
    eq2 = 1'b0; lt2 = 1'b0; gt2 = 1'b0;
    if (dplx) begin
      eq1 = (la1 == lb1);
      lt1 = (la1 <  lb1);
      gt1 = (la1 >  lb1);
      eq2 = (la2 == lb2);
      lt2 = (la2 <  lb2);
      gt2 = (la2 >  lb2);
    end else begin
      eq1 = (fa == fb);
      lt1 = (fa <  fb);
      gt1 = (fa >  fb);
    end
  end

endmodule

// File: rtl/cmp_dx_sched.sv
// Two-requester scheduler packing compatible narrow compares into one duplex comparator cycle.
module cmp_dx_sched
  import cmp_dx_sched_pkg::*;
#(
  parameter int unsigned width    = 8,
  parameter int unsigned p1_width = 4,
  parameter int unsigned cnt_w    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [1:0]       req_mode,
  input  logic [1:0]       req_tc,
  input  logic [width-1:0] a0,
  input  logic [width-1:0] b0,
  input  logic [width-1:0] a1,
  input  logic [width-1:0] b1,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [1:0]       rsp_eq,
  output logic [1:0]       rsp_lt,
  output logic [1:0]       rsp_gt,
  input  logic             cnt_clr,
  output logic [cnt_w-1:0] cnt_duplex,
  output logic [cnt_w-1:0] cnt_single
);

  localparam int unsigned W2 = width - p1_width;
  localparam logic [cnt_w-1:0] CNT_ONE = {{(cnt_w-1){1'b0}}, 1'b1};

  ptr_e             ptr_q;
  logic [1:0]       rsp_valid_q;
  flags_t           rsp_q [2];
  logic [cnt_w-1:0] cnt_dup_q, cnt_sgl_q;

  logic [1:0]       elig, grant;
  logic             pack, own;
  logic [width-1:0] core_a, core_b;
  logic             core_tc, core_dplx;
  logic             eq1, lt1, gt1, eq2, lt2, gt2;
  flags_t           res [2];

  always_comb begin
    elig  = req_valid & (~rsp_valid_q | rsp_ready);
    pack  = (&elig) && (req_mode == {MODE_LANE, MODE_LANE}) && (req_tc[0] == req_tc[1]);
    own   = (ptr_q == PTR_R1);
    grant = '0;
    if (!rst) begin
      if (pack)             grant       = '1;
      else if (elig[own])   grant[own]  = 1'b1;
      else if (elig[~own])  grant[~own] = 1'b1;
    end
    req_ready = grant;
  end

  // A lone narrow request still runs duplex, in its own lane with the other lane zeroed.
  always_comb begin
    core_a    = '0;
    core_b    = '0;
    core_tc   = 1'b0;
    core_dplx = 1'b0;
    if (grant == 2'b11) begin
      core_a    = {a1[W2-1:0], a0[p1_width-1:0]};
      core_b    = {b1[W2-1:0], b0[p1_width-1:0]};
      core_tc   = req_tc[REQ0];
      core_dplx = 1'b1;
    end else if (grant[REQ0]) begin
      core_tc = req_tc[REQ0];
      if (req_mode[REQ0] == MODE_LANE) begin
        core_a    = {{W2{1'b0}}, a0[p1_width-1:0]};
        core_b    = {{W2{1'b0}}, b0[p1_width-1:0]};
        core_dplx = 1'b1;
      end else begin
        core_a = a0;
        core_b = b0;
      end
    end else if (grant[REQ1]) begin
      core_tc = req_tc[REQ1];
      if (req_mode[REQ1] == MODE_LANE) begin
        core_a    = {a1[W2-1:0], {p1_width{1'b0}}};
        core_b    = {b1[W2-1:0], {p1_width{1'b0}}};
        core_dplx = 1'b1;
      end else begin
        core_a = a1;
        core_b = b1;
      end
    end
  end

  cmp_dx_core #(.width(width), .p1_width(p1_width)) u_core (
    .a(core_a), .b(core_b), .tc(core_tc), .dplx(core_dplx),
    .eq1(eq1), .lt1(lt1), .gt1(gt1),
    .eq2(eq2), .lt2(lt2), .gt2(gt2)
  );

  // Lane 1 doubles as the full-width result in simplex mode.
  always_comb begin
    res[REQ0] = '{eq: eq1, lt: lt1, gt: gt1};
    res[REQ1] = core_dplx ? '{eq: eq2, lt: lt2, gt: gt2} : '{eq: eq1, lt: lt1, gt: gt1};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q       <= PTR_R0;
      rsp_valid_q <= '0;
      rsp_q[0]    <= '0;
      rsp_q[1]    <= '0;
      cnt_dup_q   <= '0;
      cnt_sgl_q   <= '0;
    end else begin
      for (int unsigned r = 0; r < 2; r++) begin
        if (grant[r]) begin
          rsp_valid_q[r] <= 1'b1;
          rsp_q[r]       <= res[r];
        end else if (rsp_ready[r]) begin
          rsp_valid_q[r] <= 1'b0;
        end
      end
      if (grant == 2'b01)      ptr_q <= PTR_R1;
      else if (grant == 2'b10) ptr_q <= PTR_R0;
      if (cnt_clr) begin
        cnt_dup_q <= '0;
        cnt_sgl_q <= '0;
      end else if (grant == 2'b11) begin
        if (!(&cnt_dup_q)) cnt_dup_q <= cnt_dup_q + CNT_ONE;
      end else if (grant != 2'b00) begin
        if (!(&cnt_sgl_q)) cnt_sgl_q <= cnt_sgl_q + CNT_ONE;
      end
    end
  end

  always_comb begin
    rsp_valid = rsp_valid_q;
    for (int unsigned r = 0; r < 2; r++) begin
      rsp_eq[r] = rsp_q[r].eq;
      rsp_lt[r] = rsp_q[r].lt;
      rsp_gt[r] = rsp_q[r].gt;
    end
    cnt_duplex = cnt_dup_q;
    cnt_single = cnt_sgl_q;
  end

endmodule

// File: tb/tb_cmp_dx_sched.sv
// Self-checking bench for cmp_dx_sched: directed scenarios plus randomized traffic against a reference model.
module tb_cmp_dx_sched;

  localparam int W = 8, P1 = 4, W2 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [1:0] req_valid, req_mode, req_tc, rsp_ready;
  logic [7:0] a0, b0, a1, b1;
  logic       cnt_clr;
  logic [1:0] req_ready, rsp_valid, rsp_eq, rsp_lt, rsp_gt;
  logic [15:0] cnt_duplex, cnt_single;
  logic [1:0] s_req_ready, s_rsp_valid, s_rsp_eq, s_rsp_lt, s_rsp_gt;
  logic [1:0] s_cnt_duplex, s_cnt_single;

  cmp_dx_sched #(.width(8), .p1_width(4), .cnt_w(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_mode(req_mode), .req_tc(req_tc), .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_eq(rsp_eq), .rsp_lt(rsp_lt),
    .rsp_gt(rsp_gt), .cnt_clr(cnt_clr), .cnt_duplex(cnt_duplex), .cnt_single(cnt_single)
  );

  cmp_dx_sched #(.width(8), .p1_width(4), .cnt_w(2)) dut_s (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(s_req_ready),
    .req_mode(req_mode), .req_tc(req_tc), .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready), .rsp_eq(s_rsp_eq), .rsp_lt(s_rsp_lt),
    .rsp_gt(s_rsp_gt), .cnt_clr(cnt_clr), .cnt_duplex(s_cnt_duplex), .cnt_single(s_cnt_single)
  );

  // Reference model state
  bit [1:0] m_val, m_eq, m_lt, m_gt, m_g;
  bit       m_pk;
  int       m_ptr, m_cd, m_cs, m_cd2, m_cs2;
  int       total = 0, bad = 0;

  function automatic int sval(input int v, input int n, input bit tc);
    return (tc && v >= (1 << (n - 1))) ? v - (1 << n) : v;
  endfunction

  task automatic model_reset();
    m_val = '0; m_eq = '0; m_lt = '0; m_gt = '0;
    m_ptr = 0; m_cd = 0; m_cs = 0; m_cd2 = 0; m_cs2 = 0;
  endtask

  task automatic idle();
    req_valid = '0; req_mode = '0; req_tc = '0; rsp_ready = 2'b11; cnt_clr = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
  endtask

  // Decide which requesters the scheduler should accept with the current inputs.
  task automatic settle();
    bit [1:0] el;
    #1;
    for (int r = 0; r < 2; r++) el[r] = req_valid[r] && (!m_val[r] || rsp_ready[r]);
    m_pk = (el == 2'b11) && (req_mode == 2'b11) && (req_tc[0] == req_tc[1]);
    if (m_pk)               m_g = 2'b11;
    else if (el[m_ptr])     m_g = 2'(1 << m_ptr);
    else if (el[1 - m_ptr]) m_g = 2'(1 << (1 - m_ptr));
    else                    m_g = 2'b00;
  endtask

  task automatic clk_edge();
    int n, x, y;
    @(posedge clk);
    for (int r = 0; r < 2; r++) begin
      if (m_g[r]) begin
        n = req_mode[r] ? (r == 0 ? P1 : W2) : W;
        x = sval(int'(r == 0 ? a0 : a1) % (1 << n), n, req_tc[r]);
        y = sval(int'(r == 0 ? b0 : b1) % (1 << n), n, req_tc[r]);
        m_val[r] = 1'b1; m_eq[r] = (x == y); m_lt[r] = (x < y); m_gt[r] = (x > y);
      end else if (rsp_ready[r]) begin
        m_val[r] = 1'b0;
      end
    end
    if (m_g == 2'b01) m_ptr = 1;
    else if (m_g == 2'b10) m_ptr = 0;
    if (cnt_clr) begin
      m_cd = 0; m_cs = 0; m_cd2 = 0; m_cs2 = 0;
    end else if (m_pk) begin
      if (m_cd < 65535) m_cd++;
      if (m_cd2 < 3) m_cd2++;
    end else if (m_g != 0) begin
      if (m_cs < 65535) m_cs++;
      if (m_cs2 < 3) m_cs2++;
    end
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    req_valid = 2'b11;
    rst = 1'b1;
    model_reset();
    @(posedge clk); #1;
    total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL reset_ready got=%b want=00", req_ready); end
    total++; if (rsp_valid !== 2'b00) begin bad++; $display("FAIL reset_rsp_valid got=%b want=00", rsp_valid); end
    total++; if ({rsp_eq, rsp_lt, rsp_gt} !== 6'b0) begin bad++; $display("FAIL reset_flags got=%b want=0", {rsp_eq, rsp_lt, rsp_gt}); end
    total++; if (cnt_duplex !== 16'd0 || cnt_single !== 16'd0) begin bad++; $display("FAIL reset_cnt got=%0d/%0d want=0/0", cnt_duplex, cnt_single); end
    idle();
    rst = 1'b0;
  endtask

  task automatic test_pack();
    idle();
    req_valid = 2'b11; req_mode = 2'b11; req_tc = 2'b00;
    a0 = 8'h03; b0 = 8'h05; a1 = 8'h09; b1 = 8'h09;
    settle();
    total++; if (req_ready !== 2'b11) begin bad++; $display("FAIL pack_ready got=%b want=11", req_ready); end
    clk_edge();
    total++; if (rsp_valid !== 2'b11) begin bad++; $display("FAIL pack_valid got=%b want=11", rsp_valid); end
    total++; if (rsp_lt[0] !== 1'b1 || rsp_eq[1] !== 1'b1) begin bad++; $display("FAIL pack_flags got lt0=%b eq1=%b want 1/1", rsp_lt[0], rsp_eq[1]); end
    total++; if (cnt_duplex !== 16'd1 || cnt_single !== 16'd0) begin bad++; $display("FAIL pack_cnt got=%0d/%0d want=1/0", cnt_duplex, cnt_single); end
    idle(); settle(); clk_edge();
    total++; if (rsp_valid !== 2'b00) begin bad++; $display("FAIL pack_drain got=%b want=00", rsp_valid); end
  endtask

  task automatic test_tc_mismatch();
    idle();
    req_valid = 2'b11; req_mode = 2'b11; req_tc = 2'b01;
    a0 = 8'h08; b0 = 8'h01; a1 = 8'h02; b1 = 8'h01;
    settle();
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL tcmis_ready0 got=%b want=01", req_ready); end
    clk_edge();
    total++; if (rsp_lt[0] !== 1'b1 || rsp_valid[0] !== 1'b1) begin bad++; $display("FAIL tcmis_lt0 got=%b want=1", rsp_lt[0]); end
    settle();
    total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL tcmis_ready1 got=%b want=10", req_ready); end
    clk_edge();
    total++; if (rsp_gt[1] !== 1'b1 || rsp_valid[1] !== 1'b1) begin bad++; $display("FAIL tcmis_gt1 got=%b want=1", rsp_gt[1]); end
    total++; if (cnt_single !== 16'd2) begin bad++; $display("FAIL tcmis_cnt got=%0d want=2", cnt_single); end
    idle(); settle(); clk_edge();
  endtask

  task automatic test_full();
    idle();
    req_valid = 2'b01; req_tc = 2'b01; a0 = 8'h80; b0 = 8'h7F;
    settle(); clk_edge();
    total++; if ({rsp_eq[0], rsp_lt[0], rsp_gt[0]} !== 3'b010) begin bad++; $display("FAIL full_signed got=%b want=010", {rsp_eq[0], rsp_lt[0], rsp_gt[0]}); end
    req_tc = 2'b00;
    settle(); clk_edge();
    total++; if ({rsp_eq[0], rsp_lt[0], rsp_gt[0]} !== 3'b001) begin bad++; $display("FAIL full_unsigned got=%b want=001", {rsp_eq[0], rsp_lt[0], rsp_gt[0]}); end
    idle(); settle(); clk_edge();
  endtask

  task automatic test_backpressure();
    idle();
    req_valid = 2'b01; a0 = 8'h05; b0 = 8'h09;
    settle(); clk_edge();
    rsp_ready = 2'b10; a0 = 8'h09; b0 = 8'h05;
    for (int i = 0; i < 5; i++) begin
      settle();
      total++; if (req_ready[0] !== 1'b0) begin bad++; $display("FAIL bp_ready c%0d got=%b want=0", i, req_ready[0]); end
      clk_edge();
      total++; if (rsp_valid[0] !== 1'b1 || {rsp_eq[0], rsp_lt[0], rsp_gt[0]} !== 3'b010) begin bad++; $display("FAIL bp_hold c%0d got v=%b f=%b want v=1 f=010", i, rsp_valid[0], {rsp_eq[0], rsp_lt[0], rsp_gt[0]}); end
    end
    rsp_ready = 2'b11;
    settle();
    total++; if (req_ready[0] !== 1'b1) begin bad++; $display("FAIL bp_release got=%b want=1", req_ready[0]); end
    clk_edge();
    total++; if (rsp_valid[0] !== 1'b1 || {rsp_eq[0], rsp_lt[0], rsp_gt[0]} !== 3'b001) begin bad++; $display("FAIL bp_reload got v=%b f=%b want v=1 f=001", rsp_valid[0], {rsp_eq[0], rsp_lt[0], rsp_gt[0]}); end
    idle(); settle(); clk_edge();
  endtask

  task automatic test_reset_mid();
    idle();
    req_valid = 2'b01; a0 = 8'h11; b0 = 8'h22;
    settle(); clk_edge();
    total++; if (rsp_valid[0] !== 1'b1) begin bad++; $display("FAIL mid_pre got=%b want=1", rsp_valid[0]); end
    rsp_ready = 2'b00; req_valid = 2'b11;
    rst = 1'b1;
    #1;
    total++; if (rsp_valid !== 2'b00 || req_ready !== 2'b00) begin bad++; $display("FAIL mid_async got v=%b r=%b want 00/00", rsp_valid, req_ready); end
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    rsp_ready = 2'b11;
    settle();
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL mid_ptr got=%b want=01", req_ready); end
    clk_edge();
    idle(); settle(); clk_edge();
  endtask

  task automatic test_fairness_sat();
    do_reset();
    req_valid = 2'b11; req_mode = 2'b00;
    for (int i = 0; i < 6; i++) begin
      a0 = 8'($urandom); b0 = 8'($urandom); a1 = 8'($urandom); b1 = 8'($urandom);
      req_tc = 2'($urandom);
      settle();
      total++; if (req_ready !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin bad++; $display("FAIL fair c%0d got=%b want=%b", i, req_ready, (i % 2 == 0) ? 2'b01 : 2'b10); end
      clk_edge();
      if (i == 4) begin
        total++; if (s_cnt_single !== 2'd3) begin bad++; $display("FAIL sat_5 got=%0d want=3", s_cnt_single); end
      end
    end
    total++; if (cnt_single !== 16'd6 || cnt_duplex !== 16'd0) begin bad++; $display("FAIL fair_cnt got=%0d/%0d want=6/0", cnt_single, cnt_duplex); end
    req_valid = 2'b01; cnt_clr = 1'b1;
    settle(); clk_edge();
    total++; if (cnt_single !== 16'd0 || s_cnt_single !== 2'd0 || rsp_valid[0] !== 1'b1) begin bad++; $display("FAIL clr_prio got=%0d/%0d v=%b want=0/0 v=1", cnt_single, s_cnt_single, rsp_valid[0]); end
    idle(); settle(); clk_edge();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      req_valid = 2'($urandom); req_mode = 2'($urandom);
      req_tc = ($urandom_range(0, 2) == 0) ? 2'($urandom) : {2{1'($urandom)}};
      rsp_ready = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
      cnt_clr = ($urandom_range(0, 29) == 0);
      a0 = 8'($urandom); a1 = 8'($urandom);
      b0 = ($urandom_range(0, 3) == 0) ? a0 : 8'($urandom);
      b1 = ($urandom_range(0, 3) == 0) ? a1 : 8'($urandom);
      settle();
      total++; if (req_ready !== m_g || s_req_ready !== m_g) begin bad++; $display("FAIL rnd_ready c%0d got=%b/%b want=%b", i, req_ready, s_req_ready, m_g); end
      clk_edge();
      total++; if (rsp_valid !== m_val) begin bad++; $display("FAIL rnd_valid c%0d got=%b want=%b", i, rsp_valid, m_val); end
      for (int r = 0; r < 2; r++) begin
        if (m_val[r]) begin
          total++;
          if ({rsp_eq[r], rsp_lt[r], rsp_gt[r]} !== {m_eq[r], m_lt[r], m_gt[r]}) begin
            bad++; $display("FAIL rnd_flags c%0d r%0d got=%b want=%b", i, r, {rsp_eq[r], rsp_lt[r], rsp_gt[r]}, {m_eq[r], m_lt[r], m_gt[r]});
          end
        end
      end
      total++; if (int'(cnt_duplex) !== m_cd || int'(cnt_single) !== m_cs) begin bad++; $display("FAIL rnd_cnt c%0d got=%0d/%0d want=%0d/%0d", i, cnt_duplex, cnt_single, m_cd, m_cs); end
      total++; if (int'(s_cnt_duplex) !== m_cd2 || int'(s_cnt_single) !== m_cs2) begin bad++; $display("FAIL rnd_satcnt c%0d got=%0d/%0d want=%0d/%0d", i, s_cnt_duplex, s_cnt_single, m_cd2, m_cs2); end
    end
    idle(); settle(); clk_edge();
  endtask

  initial begin
    idle();
    rst = 1'b1;
    #1;
    test_reset();
    test_pack();
    test_tc_mismatch();
    test_full();
    test_backpressure();
    test_reset_mid();
    test_fairness_sat();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
